kernel_launch_sched: RTL and testbench
======================================

Name: kernel_launch_sched

Overview:
- Shares one HLS kernel instance with ap_ctrl_chain block control among NREQ requesters; the kernel is the tensor-slice wrapper in the tensor_slice_test top.
- Round-robin arbitration; one transaction in flight at a time.
- Per launch: latches the winner's argument word, drives ap_start until ap_ready, waits for ap_done, then pulses ap_continue and signals completion back to the owning requester.
- Sits between the requester logic and the kernel's block-control port.

Parameters:
- NREQ, 4, number of requesters (2..16).
- ARG_W, 32, width of the per-launch argument word forwarded to the kernel.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester launch request; level, held until accepted.
- req_arg  in  NREQ*ARG_W  packed argument words; requester i owns bits [i*ARG_W +: ARG_W].
- req_accept  out  NREQ  one-hot, 1-cycle pulse: request captured.
- req_done  out  NREQ  one-hot, 1-cycle pulse: the kernel finished that requester's job.
- k_ap_start  out  1  kernel ap_start.
- k_ap_ready  in  1  kernel ap_ready.
- k_ap_done  in  1  kernel ap_done; the kernel holds it until ap_continue.
- k_ap_continue  out  1  kernel ap_continue.
- k_arg  out  ARG_W  latched argument of the current transaction.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NREQ)  index of the current or last owner.
- txn_count  out  CNT_W  completed transactions; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE, rr_ptr = NREQ-1 (requester 0 has first priority).
- All outputs are 0 at reset, including k_arg and grant_id.
- FSM states:
  - IDLE: if any req_valid, pick the first set bit searching from rr_ptr+1 with wrap-around. In the same cycle:
    - req_accept[w] = 1
    - latch k_arg <= req_arg[w] and grant_id <= w
    - rr_ptr <= w
    - go to START
  - START: k_ap_start = 1.
    - On k_ap_ready=1 and k_ap_done=1 in the same cycle: go to DONE.
    - On k_ap_ready=1 alone: go to RUN.
    - Otherwise stay in START.
  - RUN: k_ap_start = 0; on k_ap_done=1 go to DONE.
  - DONE: for exactly one cycle:
    - k_ap_continue = 1
    - req_done[grant_id] = 1
    - txn_count += 1
    - then return to IDLE.
- Minimum launch-to-launch spacing: IDLE(1) + START(≥1) + DONE(1) = 3 cycles.
- A new accept can occur in the cycle after DONE.
- k_ap_start, k_ap_continue and req_* are registered state decodes; there is no combinational path from kernel inputs to outputs.
- k_arg is stable from the cycle after accept until the next accept.
- req_valid deasserted after accept has no effect on the running transaction.
- k_ap_done seen in IDLE, or before ap_ready in START, is ignored: no continue, no count.
- Only the winning requester sees req_accept; losers keep req_valid asserted and win in round-robin order.
- A winner that re-requests immediately after completion gets lowest priority on the next arbitration.
- Reset asserted mid-transaction:
  - aborts to IDLE next cycle with all outputs 0 and no req_done pulse;
  - the kernel shares the same reset.

Optional Feature:
- Macro: KSCHED_LAT_STATS_EN.
- When defined, two output ports are added:
  - last_latency (16 bits): cycles from START entry to the cycle k_ap_done is sampled, updated on entry to DONE, saturating at 16'hFFFF.
  - max_latency (16 bits): running maximum of last_latency.
  - Both reset to 0.
- When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package kernel_sched_pkg holds:
  - typedef sched_state_e {IDLE, START, RUN, DONE};
  - localparam LAT_W = 16;
  - function rr_pick(req, ptr) returning the next winner index.
- One sub-module: rr_arbiter (NREQ-wide rotating-priority one-hot picker).
  - Inputs: req, ptr.
  - Outputs: valid, idx, onehot.
  - Purely combinational.

Test Plan:
- Single request, NREQ=4: req_valid=4'b0100 with kernel ap_ready after 2 cycles and ap_done after 10 → req_accept=0100 once, k_ap_start high 3 cycles, k_ap_continue one pulse, req_done=0100, txn_count=1.
- Contention: req_valid=4'b1111 held → accept order 0,1,2,3,0; every req_done matches grant_id; never two accepts without an intervening DONE.
- Simultaneous ready/done: kernel raises ap_ready and ap_done in the same START cycle → FSM skips RUN; continue in the next cycle; transaction is 3 cycles total.
- Spurious done: k_ap_done pulsed while IDLE → no k_ap_continue, no req_done, txn_count unchanged.
- Reset mid-RUN: assert reset for 1 cycle during RUN → next cycle busy=0, all outputs 0, no req_done; a subsequent request from requester 2 is serviced normally, since the reset pointer gives priority order 0,1,2,3.
- With KSCHED_LAT_STATS_EN: latencies 5, then 12, then 7 → last_latency=7, max_latency=12; with ap_done withheld for 70000 cycles → last_latency=16'hFFFF.

Source files
------------

// File: rtl/kernel_sched_pkg.sv
// Shared types and helpers for the kernel launch scheduler.
package kernel_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int LAT_W = 16;

  // Returns the first set bit of req searching upward from ptr+1 with wrap
  // at nreq. The caller qualifies the result with |req. req is zero-padded
  // to 16 bits so one function serves every legal NREQ.
  function automatic int rr_pick(input logic [15:0] req, input int ptr, input int nreq);
    int  pick;
    int  cand;
    bit  found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cand = ptr + k;
      if (cand >= nreq) cand = cand - nreq;
      if (!found && (k <= nreq) && req[cand[3:0]]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/kernel_launch_sched_rr_arbiter.sv
// Rotating-priority one-hot picker: the requester just after ptr wins first.
module rr_arbiter
  import kernel_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);

  logic [15:0] req_ext;
  int          pick;

  // Widen the request vector to the picker's fixed width and search from ptr+1.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, int'(ptr), NREQ);
  end

  assign valid = |req;
  assign idx   = IDX_W'(pick);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign onehot[gi] = valid && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/kernel_launch_sched.sv
// Shares one ap_ctrl_chain kernel among NREQ requesters, one launch at a time,
// with round-robin arbitration. Optional latency statistics are compiled in
// when the macro KSCHED_LAT_STATS_EN is defined.
module kernel_launch_sched
  import kernel_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int ARG_W = 32,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ARG_W-1:0] req_arg,
  output logic [NREQ-1:0]       req_accept,
  output logic [NREQ-1:0]       req_done,
  output logic                  k_ap_start,
  input  logic                  k_ap_ready,
  input  logic                  k_ap_done,
  output logic                  k_ap_continue,
  output logic [ARG_W-1:0]      k_arg,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_id,
  output logic [CNT_W-1:0]      txn_count
`ifdef KSCHED_LAT_STATS_EN
  ,
  output logic [LAT_W-1:0]      last_latency,
  output logic [LAT_W-1:0]      max_latency
`endif
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [ARG_W-1:0] arg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic [NREQ-1:0]  arb_onehot;
  logic [ARG_W-1:0] arg_arr [NREQ];
  logic [NREQ-1:0]  done_onehot;
  logic             accept_fire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .valid  (arb_valid),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign arg_arr[gi]     = req_arg[gi*ARG_W +: ARG_W];
      assign done_onehot[gi] = (grant_q == IDX_W'(gi));
    end
  endgenerate

  // Accept only from IDLE; reset masks it so nothing is acknowledged then dropped.
  assign accept_fire = (state_q == IDLE) && arb_valid && !reset;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ap_done only counts once ap_ready has been seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = START;
      START: begin
        if (k_ap_ready && k_ap_done) state_d = DONE;
        else if (k_ap_ready)         state_d = RUN;
      end
      RUN:     if (k_ap_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state (accept also needs the live pick).
  always_comb begin
    req_accept    = '0;
    req_done      = '0;
    k_ap_start    = 1'b0;
    k_ap_continue = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE:  if (accept_fire) req_accept = arb_onehot;
      START: k_ap_start = 1'b1;
      DONE: begin
        k_ap_continue = 1'b1;
        req_done      = done_onehot;
      end
      default: ;
    endcase
  end

  // Per-launch context and completion counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(NREQ - 1);
      grant_q  <= '0;
      arg_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept_fire) begin
        rr_ptr_q <= arb_idx;
        grant_q  <= arb_idx;
        arg_q    <= arg_arr[arb_idx];
      end
      if (state_q == DONE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign k_arg     = arg_q;
  assign grant_id  = grant_q;
  assign txn_count = cnt_q;

`ifdef KSCHED_LAT_STATS_EN
  logic [LAT_W-1:0] lat_run_q, last_lat_q, max_lat_q;

  // Count cycles since START entry; capture on the transition into DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_run_q  <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      if (accept_fire) begin
        lat_run_q <= '0;
      end else if (((state_q == START) || (state_q == RUN)) && (lat_run_q != '1)) begin
        lat_run_q <= lat_run_q + LAT_W'(1);
      end
      if ((state_q != DONE) && (state_d == DONE)) begin
        last_lat_q <= lat_run_q;
        if (lat_run_q > max_lat_q) max_lat_q <= lat_run_q;
      end
    end
  end

  assign last_latency = last_lat_q;
  assign max_latency  = max_lat_q;
`endif

endmodule

// File: tb/tb_kernel_launch_sched.sv
// Randomised bench for kernel_launch_sched. The reference model predicts each
// transaction as a timeline (accept cycle plus kernel ready/done offsets) and
// compares every DUT output every cycle. Define KSCHED_LAT_STATS_EN to also
// exercise the latency statistics.
module tb_kernel_launch_sched;

  localparam int NREQ  = 4;
  localparam int ARG_W = 32;
  localparam int CNT_W = 16;
  localparam int IDX_W = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ARG_W-1:0] req_arg;
  logic [NREQ-1:0]       req_accept;
  logic [NREQ-1:0]       req_done;
  logic                  k_ap_start;
  logic                  k_ap_ready;
  logic                  k_ap_done;
  logic                  k_ap_continue;
  logic [ARG_W-1:0]      k_arg;
  logic                  busy;
  logic [IDX_W-1:0]      grant_id;
  logic [CNT_W-1:0]      txn_count;
`ifdef KSCHED_LAT_STATS_EN
  logic [15:0]           last_latency;
  logic [15:0]           max_latency;
`endif

  always #5 clock = ~clock;

  kernel_launch_sched #(.NREQ(NREQ), .ARG_W(ARG_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_arg       (req_arg),
    .req_accept    (req_accept),
    .req_done      (req_done),
    .k_ap_start    (k_ap_start),
    .k_ap_ready    (k_ap_ready),
    .k_ap_done     (k_ap_done),
    .k_ap_continue (k_ap_continue),
    .k_arg         (k_arg),
    .busy          (busy),
    .grant_id      (grant_id),
    .txn_count     (txn_count)
`ifdef KSCHED_LAT_STATS_EN
    ,
    .last_latency  (last_latency),
    .max_latency   (max_latency)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit               in_txn;
  int               a_cyc, m_r, m_d, m_w, m_ptr, m_grant, m_cnt, m_last, m_max;
  logic [ARG_W-1:0] m_karg;
  bit               pend [NREQ];
  logic [ARG_W-1:0] parg [NREQ];

  // Stimulus controls
  bit rand_req, hold_all, spur_done, rst_now;
  int force_r = -1;
  int force_d = -1;

  // Observations of the DUT for directed checks
  int obs_acc[$];
  int obs_start_n, obs_cont_n, obs_busy_n;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    in_txn  = 1'b0;
    m_ptr   = NREQ - 1;
    m_grant = 0;
    m_karg  = '0;
    m_cnt   = 0;
    m_last  = 0;
    m_max   = 0;
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < NREQ; i++) a |= pend[i];
    return a;
  endfunction

  task automatic run_cycle();
    int              rel, endr, w, lat;
    logic [NREQ-1:0] exp_acc, exp_dn;
    bit              exp_start, exp_cont, exp_busy, rdy, dn;
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && (hold_all || (rand_req && $urandom_range(0, 3) == 0))) begin
        pend[i] = 1'b1;
        parg[i] = $urandom;
      end
    end
    exp_acc = '0; exp_dn = '0; exp_start = 1'b0; exp_cont = 1'b0; exp_busy = 1'b0;
    rdy = 1'b0; dn = spur_done; w = -1; rel = 0; endr = 0;
    if (in_txn) begin
      rel       = cyc - a_cyc;
      endr      = 2 + ((m_r > m_d) ? m_r : m_d);
      exp_busy  = 1'b1;
      exp_start = (rel >= 1) && (rel <= 1 + m_r);
      exp_cont  = (rel == endr);
      if (rel == endr) exp_dn[m_w] = 1'b1;
      rdy = (rel == 1 + m_r);
      dn  = (rel >= 1 + m_d) && (rel <= endr);
    end else if (!rst_now) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (w < 0 && pend[c]) w = c;
      end
      if (w >= 0) exp_acc[w] = 1'b1;
    end
    reset = rst_now;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = pend[i];
      req_arg[i*ARG_W +: ARG_W] = parg[i];
    end
    k_ap_ready = rdy;
    k_ap_done  = dn;
    #1;
    check_val("req_accept", req_accept, exp_acc);
    check_val("req_done", req_done, exp_dn);
    check_val("k_ap_start", k_ap_start, exp_start);
    check_val("k_ap_continue", k_ap_continue, exp_cont);
    check_val("busy", busy, exp_busy);
    check_val("grant_id", grant_id, m_grant);
    check_val("k_arg", k_arg, m_karg);
    check_val("txn_count", txn_count, m_cnt);
`ifdef KSCHED_LAT_STATS_EN
    check_val("last_latency", last_latency, m_last);
    check_val("max_latency", max_latency, m_max);
`endif
    for (int i = 0; i < NREQ; i++) if (req_accept[i]) obs_acc.push_back(i);
    if (k_ap_start)    obs_start_n++;
    if (k_ap_continue) obs_cont_n++;
    if (busy)          obs_busy_n++;
    // Advance the model across the coming rising edge
    if (rst_now) begin
      model_reset();
    end else if (in_txn) begin
      if (rel == endr - 1) begin
        lat    = (m_r > m_d) ? m_r : m_d;
        m_last = (lat > 65535) ? 65535 : lat;
        if (m_last > m_max) m_max = m_last;
      end
      if (rel == endr) begin
        in_txn = 1'b0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        $display("txn %0d: req=%0d arg=%08h ready_at=%0d done_at=%0d", m_cnt, m_w, m_karg, m_r, m_d);
      end
    end else if (w >= 0) begin
      in_txn  = 1'b1;
      a_cyc   = cyc;
      m_w     = w;
      m_ptr   = w;
      m_grant = w;
      m_karg  = parg[w];
      pend[w] = 1'b0;
      m_r     = (force_r >= 0) ? force_r : int'($urandom_range(0, 4));
      m_d     = (force_d >= 0) ? force_d : int'($urandom_range(0, 6));
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    rst_now = 1'b1;
    run_cycle();
    rst_now = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && (in_txn || any_pend()); n++) run_cycle();
    run_cycle();
    check_val("drain_idle", busy, 0);
  endtask

  task automatic clear_obs();
    obs_acc.delete();
    obs_start_n = 0;
    obs_cont_n  = 0;
    obs_busy_n  = 0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_arg = '0; k_ap_ready = 1'b0; k_ap_done = 1'b0;
    rand_req = 1'b0; hold_all = 1'b0; spur_done = 1'b0; rst_now = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; parg[i] = '0; end
    model_reset();
    repeat (2) @(posedge clock);

    // Reset state
    run_cycle();

    // Single request from requester 2: ready after 2 cycles, done after 10
    clear_obs();
    pend[2] = 1'b1; parg[2] = 32'hA5A5_0002; force_r = 2; force_d = 10;
    repeat (16) run_cycle();
    check_val("single_start_cycles", obs_start_n, 3);
    check_val("single_continue", obs_cont_n, 1);
    check_val("single_count", txn_count, 1);
    check_val("single_accept_idx", (obs_acc.size() == 1) ? obs_acc[0] : -1, 2);

    // Contention from reset priority: all four hold their requests
    pulse_reset();
    clear_obs();
    force_r = -1; force_d = -1; hold_all = 1'b1;
    for (int n = 0; n < 200 && obs_acc.size() < 5; n++) run_cycle();
    hold_all = 1'b0;
    check_val("contention_accepts", obs_acc.size(), 5);
    for (int k = 0; k < 5 && k < obs_acc.size(); k++)
      check_val($sformatf("contention_order%0d", k), obs_acc[k], k % NREQ);
    drain(200);

    // Simultaneous ready and done in the first START cycle
    clear_obs();
    pend[1] = 1'b1; parg[1] = 32'h0000_1111; force_r = 0; force_d = 0;
    repeat (5) run_cycle();
    check_val("simul_start_cycles", obs_start_n, 1);
    check_val("simul_continue", obs_cont_n, 1);
    check_val("simul_busy_cycles", obs_busy_n, 2);

    // Spurious ap_done while idle
    clear_obs();
    spur_done = 1'b1;
    repeat (3) run_cycle();
    spur_done = 1'b0;
    run_cycle();
    check_val("spurious_continue", obs_cont_n, 0);
    check_val("spurious_busy", obs_busy_n, 0);

    // Reset during RUN, then requester 2 is serviced normally
    clear_obs();
    pend[3] = 1'b1; parg[3] = 32'hDEAD_0003; force_r = 1; force_d = 6;
    repeat (5) run_cycle();
    check_val("pre_reset_in_run", busy && !k_ap_start, 1);
    pulse_reset();
    check_val("post_reset_continue", obs_cont_n, 0);
    pend[2] = 1'b1; parg[2] = 32'hBEEF_0002; force_r = -1; force_d = -1;
    drain(40);
    check_val("post_reset_count", txn_count, 1);

    // Randomised traffic
    rand_req = 1'b1;
    repeat (400) run_cycle();
    rand_req = 1'b0;
    drain(300);

`ifdef KSCHED_LAT_STATS_EN
    // Latency statistics: 5, 12, 7 then a saturating run
    pulse_reset();
    force_r = 1;
    force_d = 5;  pend[0] = 1'b1; drain(100);
    force_d = 12; pend[0] = 1'b1; drain(100);
    force_d = 7;  pend[0] = 1'b1; drain(100);
    check_val("stats_last", last_latency, 7);
    check_val("stats_max", max_latency, 12);
    force_r = 0; force_d = 70000; pend[1] = 1'b1;
    drain(70100);
    check_val("stats_saturate", last_latency, 16'hFFFF);
    check_val("stats_max_saturate", max_latency, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
